// File: rtl/coproc_sequencer.sv
// Command sequencer for a matrix coprocessor: accepts an op, streams up to three
// 5x5 byte matrices, issues the op, waits for completion and hands back one result byte.
module coproc_sequencer #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [2:0]   cmd_op,
   input  logic [1:0]   cmd_size,
   input  logic         byte_valid,
   output logic         byte_ready,
   input  logic [7:0]   byte_data,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [7:0]   res_data,
   output logic         busy,
   output logic         error,
   output logic [2:0]   cp_op_code,
   output logic [1:0]   cp_matrix_size,
   output logic [199:0] cp_matrix_a,
   output logic [199:0] cp_matrix_b,
   output logic [199:0] cp_matrix_c,
   input  logic         cp_process_done,
   input  logic [199:0] cp_result
);

   localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE, LOAD_A, LOAD_B, LOAD_C, ISSUE, WAIT, RESP
   } state_t;

   state_t            state;
   logic [2:0]        op_q;
   logic [1:0]        size_q;
   logic [2:0]        row;
   logic [2:0]        col;
   logic [WAIT_W-1:0] wait_cnt;
   logic [2:0]        last_rc;
   logic [4:0]        elem_idx;
   logic              last_elem;

   // Matrices are always stored on a 5x5 grid, so a smaller n leaves the tail of each row zero.
   assign last_rc   = {1'b0, size_q} + 3'd1;
   assign elem_idx  = ({2'b00, row} * 5'd5) + {2'b00, col};
   assign last_elem = (row == last_rc) && (col == last_rc);

   assign cmd_ready      = (state == IDLE);
   assign byte_ready     = (state == LOAD_A) || (state == LOAD_B) || (state == LOAD_C);
   assign res_valid      = (state == RESP);
   assign busy           = (state != IDLE);
   assign cp_op_code     = ((state == ISSUE) || (state == WAIT)) ? op_q : 3'b000;
   assign cp_matrix_size = size_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         op_q        <= '0;
         size_q      <= '0;
         row         <= '0;
         col         <= '0;
         wait_cnt    <= '0;
         cp_matrix_a <= '0;
         cp_matrix_b <= '0;
         cp_matrix_c <= '0;
         res_data    <= '0;
         error       <= 1'b0;
      end else begin
         error <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  if ((cmd_op == 3'd6) || (cmd_op == 3'd7)) begin
                     op_q        <= cmd_op;
                     size_q      <= cmd_size;
                     cp_matrix_a <= '0;
                     cp_matrix_b <= '0;
                     cp_matrix_c <= '0;
                     row         <= '0;
                     col         <= '0;
                     state       <= LOAD_A;
                  end else begin
                     error <= 1'b1;
                  end
               end
            end
            LOAD_A, LOAD_B, LOAD_C: begin
               if (byte_valid) begin
                  if (state == LOAD_A)      cp_matrix_a[8*elem_idx +: 8] <= byte_data;
                  else if (state == LOAD_B) cp_matrix_b[8*elem_idx +: 8] <= byte_data;
                  else                      cp_matrix_c[8*elem_idx +: 8] <= byte_data;
                  if (last_elem) begin
                     row <= '0;
                     col <= '0;
                     if (state == LOAD_A)                      state <= LOAD_B;
                     else if ((state == LOAD_B) && (op_q == 3'd7)) state <= LOAD_C;
                     else                                      state <= ISSUE;
                  end else if (col == last_rc) begin
                     col <= '0;
                     row <= row + 3'd1;
                  end else begin
                     col <= col + 3'd1;
                  end
               end
            end
            ISSUE: begin
               wait_cnt <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               // Done wins over timeout on the final allowed cycle; the counter stops at its limit.
               if (cp_process_done) begin
                  res_data <= cp_result[7:0];
                  state    <= RESP;
               end else if (wait_cnt >= WAIT_LAST) begin
                  error    <= 1'b1;
                  res_data <= '0;
                  state    <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            RESP: begin
               if (res_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_coproc_sequencer.sv
// Scoreboard bench for coproc_sequencer: driver pushes expected results, a monitor
// pops and compares them; the coprocessor is a stub with a programmable done delay.
module tb_coproc_sequencer;

   logic         clk = 1'b0;
   logic         reset;
   logic         cmd_valid, cmd_ready;
   logic [2:0]   cmd_op;
   logic [1:0]   cmd_size;
   logic         byte_valid, byte_ready;
   logic [7:0]   byte_data;
   logic         res_valid, res_ready;
   logic [7:0]   res_data;
   logic         busy, error;
   logic [2:0]   cp_op_code;
   logic [1:0]   cp_matrix_size;
   logic [199:0] cp_matrix_a, cp_matrix_b, cp_matrix_c;
   logic         cp_process_done;
   logic [199:0] cp_result;

   always #5 clk = ~clk;

   coproc_sequencer #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_size(cmd_size),
      .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .busy(busy), .error(error),
      .cp_op_code(cp_op_code), .cp_matrix_size(cp_matrix_size),
      .cp_matrix_a(cp_matrix_a), .cp_matrix_b(cp_matrix_b), .cp_matrix_c(cp_matrix_c),
      .cp_process_done(cp_process_done), .cp_result(cp_result)
   );

   typedef struct {
      logic [2:0]   op;
      logic [199:0] a, b, c;
      logic [7:0]   data;
      logic         err;
      int           rise;
   } exp_t;

   exp_t sb[$];
   exp_t pending;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int stub_delay = 0;
   int stub_cnt   = 0;
   int hold_cnt   = 0;
   bit err_ok     = 1'b0;

   logic [7:0] stim [3][25];
   logic [7:0] mdl  [3][5][5];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [199:0] act, input logic [199:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic logic [199:0] pack(input int mi);
      logic [199:0] p = '0;
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++)
            p[8*(r*5+c) +: 8] = mdl[mi][r][c];
      return p;
   endfunction

   // Coprocessor stub: done rises in WAIT cycle stub_delay+1 and stays up until the op ends.
   always @(negedge clk) begin
      if (cp_op_code != 3'b000) begin
         stub_cnt = stub_cnt + 1;
         cp_process_done = (stub_cnt >= stub_delay + 2);
      end else begin
         stub_cnt = 0;
         cp_process_done = 1'b0;
      end
   end

   // Monitor: matrix check at issue, timing/error at result start, stability, pop on handshake.
   initial begin : monitor
      logic       prev_valid = 1'b0;
      logic       prev_acc   = 1'b0;
      logic [7:0] prev_data  = '0;
      logic [2:0] prev_op    = '0;
      exp_t       e;
      res_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_valid = 1'b0; prev_acc = 1'b0; prev_op = '0; res_ready = 1'b0;
            continue;
         end
         if (cp_op_code != 3'b000 && prev_op == 3'b000) begin
            if (sb.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_issue: got op %0d expected no issue", cp_op_code);
            end else begin
               check("issue_op", cp_op_code, sb[0].op);
               check("matrix_a", cp_matrix_a, sb[0].a);
               check("matrix_b", cp_matrix_b, sb[0].b);
               check("matrix_c", cp_matrix_c, sb[0].c);
            end
         end
         if (res_valid && !prev_valid) begin
            if (sb.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_res_valid: got res_data %0h expected no result", res_data);
            end else begin
               check("res_valid_cycle", cyc, sb[0].rise);
               check("error_at_result", error, sb[0].err);
            end
         end else if (error && !err_ok) begin
            n_tests++; n_fail++;
            $display("FAIL spurious_error: got 1 expected 0 at cycle %0d", cyc);
         end
         if (res_valid && prev_valid && !prev_acc) begin
            check("res_data_stable", res_data, prev_data);
            check("cmd_ready_in_resp", cmd_ready, 1'b0);
         end
         if (res_valid && hold_cnt > 0) begin
            hold_cnt--;
            res_ready = 1'b0;
         end else begin
            res_ready = ($urandom_range(0, 3) != 0);
         end
         prev_acc = 1'b0;
         if (res_valid && res_ready) begin
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("res_data", res_data, e.data);
            end
            prev_acc = 1'b1;
         end
         prev_valid = res_valid;
         prev_data  = res_data;
         prev_op    = cp_op_code;
      end
   end

   task automatic issue_cmd(input logic [2:0] op, input logic [1:0] size);
      int g = 0;
      cmd_valid = 1'b1; cmd_op = op; cmd_size = size;
      while (!cmd_ready && g < 50) begin @(negedge clk); g++; end
      if (!cmd_ready) begin
         n_tests++; n_fail++;
         $display("FAIL cmd_ready_timeout: got 0 expected 1");
      end
      @(negedge clk);
      cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_size = 2'($urandom);
   endtask

   task automatic send_byte(input logic [7:0] v, input bit last);
      int g = 0;
      byte_valid = 1'b1; byte_data = v;
      cmd_valid = 1'($urandom_range(0, 1)); cmd_op = 3'($urandom);
      while (!byte_ready && g < 50) begin @(negedge clk); g++; end
      if (!byte_ready) begin
         n_tests++; n_fail++;
         $display("FAIL byte_ready_timeout: got 0 expected 1");
      end else if (last) begin
         pending.rise = pending.rise + cyc;
         sb.push_back(pending);
      end
      @(negedge clk);
      byte_valid = 1'b0; byte_data = 8'($urandom); cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int g = 0;
      while (busy && g < 300) begin
         byte_valid = 1'($urandom_range(0, 1));
         @(negedge clk); g++;
      end
      byte_valid = 1'b0;
      n_tests++;
      if (busy) begin
         n_fail++;
         $display("FAIL idle_timeout: got busy 1 expected 0");
      end
   endtask

   // Full transaction: model the matrices, build the expectation, stream bytes, wait for idle.
   task automatic run_cmd(input logic [2:0] op, input logic [1:0] size, input int delay,
                          input int hold, input int gap, input bit fixed, input int res_lo);
      int n = size + 2;
      int nm = (op == 3'd7) ? 3 : 2;
      for (int m = 0; m < 3; m++) begin
         for (int k = 0; k < 25; k++) begin
            if (!fixed) stim[m][k] = 8'($urandom);
            mdl[m][k/5][k%5] = '0;
         end
      end
      for (int m = 0; m < nm; m++)
         for (int k = 0; k < n*n; k++)
            mdl[m][k/n][k%n] = stim[m][k];
      stub_delay = delay;
      for (int w = 0; w < 7; w++) cp_result[w*32 +: 32] = $urandom;
      if (res_lo >= 0) cp_result[7:0] = 8'(res_lo);
      hold_cnt = hold;
      pending.op   = op;
      pending.a    = pack(0);
      pending.b    = pack(1);
      pending.c    = pack(2);
      pending.err  = (delay > 15);
      pending.data = (delay > 15) ? 8'h00 : cp_result[7:0];
      pending.rise = (delay > 15) ? 18 : 3 + delay;
      issue_cmd(op, size);
      for (int m = 0; m < nm; m++) begin
         for (int k = 0; k < n*n; k++) begin
            repeat ($urandom_range(0, gap)) begin
               byte_data = 8'($urandom); cmd_valid = 1'($urandom_range(0, 1)); cmd_op = 3'd6;
               @(negedge clk);
            end
            send_byte(stim[m][k], (m == nm-1) && (k == n*n-1));
         end
      end
      cmd_valid = 1'b0;
      wait_idle();
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      logic [7:0] b_fix [9];
      reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_size = '0;
      byte_valid = 1'b0; byte_data = '0; cp_result = '0; cp_process_done = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("rst_cmd_ready", cmd_ready, 1'b1);
      check("rst_byte_ready", byte_ready, 1'b0);
      check("rst_res_valid", res_valid, 1'b0);
      check("rst_res_data", res_data, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_error", error, 1'b0);
      check("rst_cp_op_code", cp_op_code, 3'b000);
      check("rst_cp_size", cp_matrix_size, 2'b00);
      check("rst_mat_a", cp_matrix_a, 200'd0);
      check("rst_mat_b", cp_matrix_b, 200'd0);
      check("rst_mat_c", cp_matrix_c, 200'd0);
      @(negedge clk);
      check("cmd_ready_after_release", cmd_ready, 1'b1);

      // 3x3 example: A = 1..9, B = small kernel, done immediately with result 0x2A.
      b_fix = '{8'd0, 8'd1, 8'd0, 8'd1, 8'hFC, 8'd1, 8'd0, 8'd1, 8'd0};
      for (int k = 0; k < 9; k++) begin
         stim[0][k] = 8'(k + 1);
         stim[1][k] = b_fix[k];
      end
      run_cmd(3'd6, 2'd1, 0, 0, 0, 1'b1, 8'h2A);
      check("ex_a_idx7", cp_matrix_a[63:56], 8'd6);
      check("ex_a_upper_zero", cp_matrix_a[199:104], 96'd0);
      check("ex_b_idx6", cp_matrix_b[55:48], 8'hFC);
      check("ex_size", cp_matrix_size, 2'd1);

      // Unsupported op: single-cycle error, stays idle, matrices untouched.
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 3'd3; cmd_size = 2'd2; err_ok = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("badop_error", error, 1'b1);
      check("badop_cmd_ready", cmd_ready, 1'b1);
      check("badop_byte_ready", byte_ready, 1'b0);
      check("badop_mat_a", cp_matrix_a, pack(0));
      check("badop_size", cp_matrix_size, 2'd1);
      @(negedge clk);
      check("badop_error_pulse", error, 1'b0);
      err_ok = 1'b0;

      // 5x5, three matrices, random gaps.
      run_cmd(3'd7, 2'd3, 2, 0, 3, 1'b0, -1);
      // Done never arrives: timeout error, zero result, held response.
      run_cmd(3'd6, 2'd0, 1000, 3, 1, 1'b0, -1);
      // Response back-pressure for 10 cycles.
      run_cmd(3'd6, 2'd2, 4, 10, 1, 1'b0, -1);
      // Done exactly on the last permitted WAIT cycle, then one cycle too late.
      run_cmd(3'd7, 2'd0, 15, 0, 0, 1'b0, -1);
      run_cmd(3'd6, 2'd1, 16, 0, 0, 1'b0, -1);

      // Reset part-way through loading B.
      for (int k = 0; k < 9; k++) begin
         stim[0][k] = 8'($urandom_range(1, 255));
         stim[1][k] = 8'($urandom_range(1, 255));
      end
      issue_cmd(3'd6, 2'd1);
      for (int k = 0; k < 9; k++) send_byte(stim[0][k], 1'b0);
      for (int k = 0; k < 5; k++) send_byte(stim[1][k], 1'b0);
      check("midload_busy", busy, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midrst_busy", busy, 1'b0);
      check("midrst_mat_a", cp_matrix_a, 200'd0);
      check("midrst_mat_b", cp_matrix_b, 200'd0);
      check("midrst_res_valid", res_valid, 1'b0);
      check("midrst_error", error, 1'b0);
      repeat (5) @(negedge clk);
      check("midrst_cmd_ready", cmd_ready, 1'b1);

      for (int i = 0; i < 10; i++) begin
         run_cmd(($urandom_range(0, 1) != 0) ? 3'd7 : 3'd6, 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 4) == 0) ? 20 : $urandom_range(0, 6),
                 $urandom_range(0, 3), $urandom_range(0, 2), 1'b0, -1);
      end

      repeat (5) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/coproc_sequencer.md
COPROC_SEQUENCER -- requirements
Module: coproc_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, max WAIT cycles without cp_process_done before error.
REQ-002 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_op in 3, cmd_size in 2: command handshake, op code, matrix size (0=2x2..3=5x5).
REQ-005 SHALL have ports byte_valid in 1, byte_ready out 1, byte_data in 8: serial matrix element stream.
REQ-006 SHALL have ports res_valid out 1, res_ready in 1, res_data out 8: result pixel handshake.
REQ-007 SHALL have ports busy out 1 (not IDLE) and error out 1 (one-cycle pulse).
REQ-008 SHALL have ports cp_op_code out 3, cp_matrix_size out 2, cp_matrix_a/cp_matrix_b/cp_matrix_c out 200 each, cp_process_done in 1, cp_result in 200: coprocessor-facing side.

Function
REQ-009 SHALL implement states IDLE, LOAD_A, LOAD_B, LOAD_C, ISSUE, WAIT, RESP.
REQ-010 cmd_ready SHALL be 1 only in IDLE; command accepted on cmd_valid && cmd_ready.
REQ-011 On accepting cmd_op 6: latch op/size, zero all three matrix registers, go LOAD_A; sequence A then B.
REQ-012 On accepting cmd_op 7: same, sequence A, B, then C.
REQ-013 On accepting any other cmd_op: pulse error one cycle, stay IDLE, matrices unchanged.
REQ-014 byte_ready SHALL be 1 only in LOAD_A/B/C; one element stored per byte_valid && byte_ready.
REQ-015 With n = cmd_size+2, byte k (0..n*n-1) of a matrix SHALL be stored at row k/n, col k%n, index r*5+c, bits [8*idx+7:8*idx]; unloaded elements remain 0.
REQ-016 Element counter SHALL reset to 0 on each matrix transition; after byte n*n-1, advance to next LOAD state or, after last matrix, ISSUE.
REQ-017 cp_op_code SHALL equal latched op in ISSUE and WAIT, 3'b000 in all other states; cp_matrix_size SHALL always drive latched size.
REQ-018 cp_matrix_a/b/c SHALL drive matrix registers directly, stable from ISSUE until next command accept.
REQ-019 ISSUE SHALL last exactly one cycle, then WAIT.
REQ-020 In WAIT, first cycle cp_process_done=1 SHALL capture cp_result[7:0] into res_data and go RESP.
REQ-021 If WAIT persists TIMEOUT_CYCLES cycles without done: pulse error, res_data=0, go RESP (result still delivered).
REQ-022 res_valid SHALL be 1 exactly in RESP; res_data stable while res_valid=1; on res_ready go IDLE next cycle.
REQ-023 Latency: last byte accepted cycle t -> ISSUE t+1 -> WAIT t+2 -> res_valid at t+3 when done is already high at t+2.
REQ-024 cmd_valid outside IDLE and byte_valid outside LOAD states SHALL be ignored (no store, no state change).
REQ-025 Wait counter SHALL saturate; no wrap-around produces spurious capture.

Reset
REQ-026 reset SHALL force IDLE, all matrix registers 0, counters 0, latched op/size 0, cp_op_code 0, cmd_ready 1 the cycle after release, byte_ready 0, res_valid 0, res_data 0, busy 0, error 0.
REQ-027 reset asserted mid-LOAD, WAIT, or RESP SHALL abandon the operation with no res_valid and no error pulse.

Verification
REQ-028 Size=1, op 6, A bytes 1..9, B bytes 0,1,0,1,-4(0xFC),1,0,1,0, stub done same cycle result 0x2A -> cp_matrix_a[63:56]=6 (row1,col2 idx7), bits above idx12 zero, res_data=0x2A at t+3.
REQ-029 Size=3, op 7, 75 bytes streamed with random byte_valid gaps -> A/B/C elements match row*5+col map, res_valid exactly once.
REQ-030 cmd_op=3 -> error one cycle, cmd_ready stays 1, no byte_ready.
REQ-031 Stub never asserts done -> error after 16 WAIT cycles, res_data=0, res_valid held until res_ready.
REQ-032 res_ready held low 10 cycles -> res_valid/res_data stable throughout, cmd_ready 0 until acknowledge.
REQ-033 reset during LOAD_B after 5 bytes -> IDLE next cycle, all cp_matrix_* zero, no res_valid.
